// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: select encodings and
// the minimum multi-cycle latency.
package fwd_hazard_unit_pkg;

  localparam int unsigned FWD_SEL_RF = 0;
  localparam int unsigned MC_LAT_MIN = 1;

  // Select value that picks forwarding stage k.
  function automatic int unsigned fwd_stage_sel(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
// Per-register busy scoreboard for variable-latency multi-cycle ops,
// with the same-cycle issue bypass folded into its stall request.
module fwd_hazard_unit_mc_scoreboard
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LAT_W    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                mc_issue,
  input  logic [RA_W-1:0]     mc_rd,
  input  logic [LAT_W-1:0]    mc_lat,
  input  logic                id_valid,
  input  logic [RA_W-1:0]     id_rs1,
  input  logic [RA_W-1:0]     id_rs2,
  input  logic [RA_W-1:0]     id_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sb_stall_c
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [LAT_W-1:0] lat_eff;
  logic             bypass;

  // Reload on issue (newer op wins), otherwise count down to zero.
  always_comb begin
    lat_eff = (mc_lat < LAT_W'(MC_LAT_MIN)) ? LAT_W'(MC_LAT_MIN) : mc_lat;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (mc_issue && (mc_rd == RA_W'(r))) begin
        cnt_d[r] = lat_eff;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  assign bypass = mc_issue && (mc_rd != '0) &&
                  ((mc_rd == id_rs1) || (mc_rd == id_rs2) || (mc_rd == id_rd));

  assign sb_stall_c = id_valid &&
                      (busy_vec[id_rs1] || busy_vec[id_rs2] || busy_vec[id_rd] || bypass);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Generalised operand forwarding, load-use / scoreboard stall generation and
// stall-cycle accounting between ID/EX control and the EX operand muxes.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned LAT_W      = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [RA_W-1:0]            ex_rs1,
  input  logic [RA_W-1:0]            ex_rs2,
  input  logic                       ex_rs1_used,
  input  logic                       ex_rs2_used,
  input  logic [RA_W-1:0]            id_rs1,
  input  logic [RA_W-1:0]            id_rs2,
  input  logic [RA_W-1:0]            id_rd,
  input  logic                       id_valid,
  input  logic [FWD_STAGES*RA_W-1:0] st_rd,
  input  logic [FWD_STAGES-1:0]      st_we,
  input  logic [FWD_STAGES-1:0]      st_rdy,
  input  logic [RA_W-1:0]            me_rs2,
  input  logic                       me_mem_write,
  input  logic                       mc_issue,
  input  logic [RA_W-1:0]            mc_rd,
  input  logic [LAT_W-1:0]           mc_lat,
  output logic [SEL_W-1:0]           forwardA,
  output logic [SEL_W-1:0]           forwardB,
  output logic [SEL_W-1:0]           forward_data,
  output logic                       stall,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic [31:0]                stall_cnt
);

  logic [FWD_STAGES-1:0] hit_a;
  logic [FWD_STAGES-1:0] hit_b;
  logic [FWD_STAGES-1:0] hit_d;
  logic                  nr_a;
  logic                  nr_b;
  logic                  sb_stall_c;
  logic [31:0]           stall_cnt_q;
  logic [31:0]           stall_cnt_d;

  // Stage 0 is the store itself, so it never supplies store data.
  for (genvar k = 0; k < int'(FWD_STAGES); k++) begin : g_hit
    logic [RA_W-1:0] rd;
    logic            wr_nz;
    assign rd       = st_rd[k*RA_W +: RA_W];
    assign wr_nz    = st_we[k] && (rd != '0);
    assign hit_a[k] = ex_rs1_used && wr_nz && (rd == ex_rs1);
    assign hit_b[k] = ex_rs2_used && wr_nz && (rd == ex_rs2);
    assign hit_d[k] = (k != 0) && me_mem_write && wr_nz && (rd == me_rs2);
  end

  // Descending scan so the lowest-index (youngest) match is the last write.
  always_comb begin
    forwardA     = SEL_W'(FWD_SEL_RF);
    forwardB     = SEL_W'(FWD_SEL_RF);
    forward_data = SEL_W'(FWD_SEL_RF);
    nr_a         = 1'b0;
    nr_b         = 1'b0;
    for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
      if (hit_a[k]) begin
        forwardA = SEL_W'(fwd_stage_sel(k));
        nr_a     = !st_rdy[k];
      end
      if (hit_b[k]) begin
        forwardB = SEL_W'(fwd_stage_sel(k));
        nr_b     = !st_rdy[k];
      end
      if (hit_d[k]) begin
        forward_data = st_rdy[k] ? SEL_W'(fwd_stage_sel(k)) : SEL_W'(FWD_SEL_RF);
      end
    end
  end

  fwd_hazard_unit_mc_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .RA_W     (RA_W),
    .LAT_W    (LAT_W)
  ) u_mc_scoreboard (
    .clk        (clk),
    .rstn       (rstn),
    .mc_issue   (mc_issue),
    .mc_rd      (mc_rd),
    .mc_lat     (mc_lat),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .busy_vec   (busy_vec),
    .sb_stall_c (sb_stall_c)
  );

  assign stall = nr_a || nr_b || sb_stall_c;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit with three forwarding stages:
// directed scenarios with literal expectations plus a per-cycle model compare.
module tb_fwd_hazard_unit;

  localparam int unsigned FS = 3;
  localparam int unsigned NR = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned LW = 4;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [RW-1:0] ex_rs1, ex_rs2, id_rs1, id_rs2, id_rd, me_rs2, mc_rd;
  logic          ex_rs1_used, ex_rs2_used, id_valid, me_mem_write, mc_issue;
  logic [FS*RW-1:0] st_rd;
  logic [FS-1:0] st_we, st_rdy;
  logic [LW-1:0] mc_lat;
  logic [SW-1:0] forwardA, forwardB, forward_data;
  logic          stall;
  logic [NR-1:0] busy_vec;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int failures = 0;

  fwd_hazard_unit #(
    .FWD_STAGES(FS), .NUM_REGS(NR), .RA_W(RW), .LAT_W(LW), .SEL_W(SW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_valid(id_valid),
    .st_rd(st_rd), .st_we(st_we), .st_rdy(st_rdy),
    .me_rs2(me_rs2), .me_mem_write(me_mem_write),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat),
    .forwardA(forwardA), .forwardB(forwardB), .forward_data(forward_data),
    .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A register is busy while the model cycle number is below its release cycle.
  int          cyc = 0;
  int          rel [NR] = '{default: 0};
  int unsigned m_cnt = 0;

  function automatic bit m_busy(input int r);
    return (r != 0) && (cyc < rel[r]);
  endfunction

  function automatic int m_rd(input int k);
    logic [FS*RW-1:0] v;
    v = st_rd;
    return int'(v[k*RW +: RW]);
  endfunction

  function automatic int m_winner(input int s, input bit used);
    if (!used) return -1;
    for (int k = 0; k < int'(FS); k++)
      if (st_we[k] && m_rd(k) != 0 && m_rd(k) == s) return k;
    return -1;
  endfunction

  function automatic int m_fwd(input int s, input bit used);
    return m_winner(s, used) + 1;
  endfunction

  function automatic int m_store();
    if (!me_mem_write) return 0;
    for (int k = 1; k < int'(FS); k++)
      if (st_we[k] && m_rd(k) != 0 && m_rd(k) == int'(me_rs2)) return st_rdy[k] ? k + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_stall();
    int  wa, wb;
    bit  nr, sb;
    wa = m_winner(int'(ex_rs1), ex_rs1_used);
    wb = m_winner(int'(ex_rs2), ex_rs2_used);
    nr = (wa >= 0 && !st_rdy[wa]) || (wb >= 0 && !st_rdy[wb]);
    sb = id_valid && (m_busy(int'(id_rs1)) || m_busy(int'(id_rs2)) || m_busy(int'(id_rd)) ||
         (mc_issue && mc_rd != 0 && (mc_rd == id_rs1 || mc_rd == id_rs2 || mc_rd == id_rd)));
    return nr || sb;
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    v = '0;
    for (int r = 0; r < int'(NR); r++) v[r] = m_busy(r);
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < int'(NR); r++) rel[r] <= 0;
      m_cnt <= 0;
    end else begin
      if (m_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      if (mc_issue && mc_rd != 0)
        rel[mc_rd] <= cyc + 1 + ((mc_lat == 0) ? 1 : int'(mc_lat));
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("m_forwardA", forwardA, m_fwd(int'(ex_rs1), ex_rs1_used));
      chk("m_forwardB", forwardB, m_fwd(int'(ex_rs2), ex_rs2_used));
      chk("m_forward_data", forward_data, m_store());
      chk("m_stall", stall, m_stall());
      chk("m_busy_vec", busy_vec, m_busy_vec());
      chk("m_stall_cnt", stall_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_rs1 = 0; ex_rs2 = 0; ex_rs1_used = 0; ex_rs2_used = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_valid = 0;
    st_rd = '0; st_we = '0; st_rdy = '0;
    me_rs2 = 0; me_mem_write = 0;
    mc_issue = 0; mc_rd = 0; mc_lat = 0;
  endtask

  task automatic set_stage(input int k, input int rd, input bit we, input bit rdy);
    st_rd[k*RW +: RW] = RW'(rd);
    st_we[k]  = we;
    st_rdy[k] = rdy;
  endtask

  initial begin
    rstn = 1'b0;
    clear_in();
    #12;
    chk("reset_busy_vec", busy_vec, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_forwardA", forwardA, 0);
    chk("reset_stall", stall, 0);
    tick();
    rstn = 1'b1;
    tick();

    // Priority: all three stages write r5, youngest wins.
    for (int k = 0; k < 3; k++) set_stage(k, 5, 1, 1);
    ex_rs1 = 5; ex_rs1_used = 1;
    #1 chk("prio_all", forwardA, 1);
    st_we = 3'b110;
    #1 chk("prio_skip0", forwardA, 2);
    chk("prio_no_stall", stall, 0);
    tick();

    // Load-use: stage 0 not ready stalls, then forwards once ready.
    clear_in();
    set_stage(0, 7, 1, 0);
    ex_rs2 = 7; ex_rs2_used = 1;
    #1 chk("loaduse_stall", stall, 1);
    tick();
    st_rdy[0] = 1;
    #1 chk("loaduse_release", stall, 0);
    chk("loaduse_fwdB", forwardB, 1);
    tick();

    // x0 is never forwarded; unused operand never matches.
    clear_in();
    set_stage(0, 0, 1, 1);
    ex_rs1 = 0; ex_rs1_used = 1;
    #1 chk("x0_fwdA", forwardA, 0);
    set_stage(0, 3, 1, 0);
    ex_rs1 = 3; ex_rs1_used = 0;
    #1 chk("unused_fwdA", forwardA, 0);
    chk("unused_no_stall", stall, 0);
    tick();

    // Store-data forward from stage 1; stage 0 also matching is ignored.
    clear_in();
    me_mem_write = 1; me_rs2 = 4;
    set_stage(1, 4, 1, 1);
    set_stage(0, 4, 1, 1);
    #1 chk("store_fwd", forward_data, 2);
    me_mem_write = 0;
    #1 chk("store_off", forward_data, 0);
    tick();

    // Scoreboard: issue r9 latency 3 with ID reading r9.
    clear_in();
    chk("cnt_before_sb", stall_cnt, 1);
    id_valid = 1; id_rs1 = 9;
    mc_issue = 1; mc_rd = 9; mc_lat = 3;
    #1 chk("sb_bypass_stall", stall, 1);
    chk("sb_not_yet_busy", busy_vec[9], 0);
    tick();
    mc_issue = 0; mc_rd = 0; mc_lat = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sb_busy9", busy_vec[9], 1);
      chk("sb_busy_stall", stall, 1);
      tick();
    end
    #1 chk("sb_free9", busy_vec[9], 0);
    chk("sb_free_stall", stall, 0);
    chk("sb_stall_cnt", stall_cnt, 5);

    // Latency 0 is treated as 1.
    clear_in();
    mc_issue = 1; mc_rd = 10; mc_lat = 0;
    tick();
    mc_issue = 0; mc_rd = 0;
    #1 chk("lat0_busy", busy_vec[10], 1);
    tick();
    #1 chk("lat0_free", busy_vec[10], 0);
    chk("lat0_cnt_hold", stall_cnt, 5);

    // Short directed-random burst cross-checked by the per-cycle model.
    for (int i = 0; i < 60; i++) begin
      ex_rs1 = RW'($urandom_range(0, 6));  ex_rs2 = RW'($urandom_range(0, 6));
      ex_rs1_used = 1'($urandom);          ex_rs2_used = 1'($urandom);
      for (int k = 0; k < 3; k++) set_stage(k, int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
      me_rs2 = RW'($urandom_range(0, 6));  me_mem_write = 1'($urandom);
      id_valid = 1'($urandom);
      id_rs1 = RW'($urandom_range(0, 6));  id_rs2 = RW'($urandom_range(0, 6));
      id_rd  = RW'($urandom_range(0, 6));
      mc_issue = ($urandom_range(0, 3) == 0);
      mc_rd = RW'($urandom_range(0, 6));   mc_lat = LW'($urandom_range(0, 5));
      tick();
    end

    // Async reset mid-countdown clears state without a clock edge.
    clear_in();
    tick();
    mc_issue = 1; mc_rd = 12; mc_lat = 10;
    tick();
    mc_issue = 0; mc_rd = 0; mc_lat = 0;
    #1 chk("rst_pre_busy12", busy_vec[12], 1);
    rstn = 1'b0;
    #1 chk("rst_async_busy", busy_vec, 0);
    chk("rst_async_cnt", stall_cnt, 0);
    #5 rstn = 1'b1;
    tick();
    #1 chk("rst_after_busy", busy_vec, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Generalised forwarding and hazard unit for the AdamRiscv pipeline.
- Forwarding is parametrised over N downstream result stages, nearest stage first. Each stage reports whether its data is ready, so load-use stalls are handled uniformly.
- Adds a per-register busy scoreboard with countdown counters for variable-latency multi-cycle ops (mul/div side unit), a store-data forward select, and a saturating stall-cycle counter.
- Sits between ID/EX control and the EX operand muxes.

Parameters:
- FWD_STAGES, 2, number of forwarding source stages; stage 0 = EX/MEM, stage 1 = MEM/WB, etc.
- NUM_REGS, 32, architectural registers; index 0 hardwired zero.
- RA_W, 5, register-address width, equal to clog2(NUM_REGS).
- LAT_W, 4, width of multi-cycle latency field and per-register counter.
- SEL_W, 2, forward-select width, equal to clog2(FWD_STAGES+1).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- ex_rs1, ex_rs2  in  RA_W  EX-stage source registers
- ex_rs1_used, ex_rs2_used  in  1  operand actually read
- id_rs1, id_rs2, id_rd  in  RA_W  ID-stage registers
- id_valid  in  1  ID holds a real instruction
- st_rd  in  FWD_STAGES*RA_W  destination reg per stage, stage k at bits [k*RA_W +: RA_W]
- st_we  in  FWD_STAGES  stage k writes a register
- st_rdy  in  FWD_STAGES  stage k result is available (0 = load still in flight)
- me_rs2  in  RA_W  store-data source register in MEM
- me_mem_write  in  1  MEM holds a store
- mc_issue  in  1  multi-cycle op leaves EX this cycle
- mc_rd  in  RA_W  its destination
- mc_lat  in  LAT_W  its latency in cycles
- forwardA, forwardB  out  SEL_W  0 = ID/EX register value; k+1 = stage k
- forward_data  out  SEL_W  store-data select, same encoding, searched over stages 1..FWD_STAGES-1
- stall  out  1  freeze PC/IF/ID, insert EX bubble
- busy_vec  out  NUM_REGS  scoreboard busy bits; bit 0 always 0
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset (rstn low, async):
  - all counters 0, busy_vec 0, stall_cnt 0.
  - Combinational outputs follow inputs; with all inputs 0: forwardA = forwardB = forward_data = 0, stall = 0.
- Forward match for a source operand s:
  - Stage k matches when st_we[k] && st_rd[k] != 0 && st_rd[k] == s && s_used.
  - The lowest-index matching stage wins (youngest result).
  - Select = k+1; no match → 0.
- Not-ready hazard: the winning stage has st_rdy[k] = 0 → stall = 1 that cycle. The select value is still driven but is don't-care to consumers.
- Store data: forward_data matches me_rs2 against stages 1..FWD_STAGES-1 when me_mem_write = 1, lowest index wins, and st_rdy is required. Otherwise 0. Stage 0 is the store itself and is never a source.
- Scoreboard counters:
  - cnt[r], LAT_W bits, for r = 1..NUM_REGS-1; busy_vec[r] = (cnt[r] != 0), registered.
  - On a clock edge with mc_issue = 1 and mc_rd != 0: cnt[mc_rd] <= max(mc_lat, 1).
  - Every other counter that is nonzero decrements by 1 per edge.
  - Issue latency L → busy for exactly L cycles after the issue edge.
  - mc_rd = 0 → ignored.
  - Issue to a reg whose cnt is nonzero → reload (the newer op wins). This cannot occur while stall is honoured.
- Scoreboard stall, asserted when id_valid = 1 and any of:
  - busy_vec[id_rs1], busy_vec[id_rs2] or busy_vec[id_rd] is set (RAW/WAW), with index 0 excluded;
  - same-cycle bypass: mc_issue = 1 and mc_rd != 0 and mc_rd equals id_rs1, id_rs2 or id_rd.
- Final stall = not-ready hazard OR scoreboard stall.
- stall_cnt increments on each edge where stall = 1 and saturates at 0xFFFF_FFFF.
- Pipeline flushes do not clear the scoreboard; in-flight multi-cycle ops still write back.
- Reset asserted mid-countdown clears all busy state immediately.

Decomposition:
- Shared header define.vh gains:
  - FWD_SEL_RF = 0 and the stage-select encodings, replacing the fixed EX_MEM/MEM_WB select macros;
  - MC_LAT_MIN = 1.
- One sub-module: mc_scoreboard, holding the counter array, busy_vec and the same-cycle issue bypass.
- Forward priority search and stall OR remain in fwd_hazard_unit.

Test Plan:
- Priority: FWD_STAGES = 3, st_rd = {5,5,5}, st_we = 111, st_rdy = 111, ex_rs1 = 5 → forwardA = 1. Then st_we = 110 → forwardA = 2.
- Load-use: st_rd[0] = 7, st_we[0] = 1, st_rdy[0] = 0, ex_rs2 = 7, ex_rs2_used = 1 → stall = 1. Next cycle st_rdy[0] = 1 → stall = 0, forwardB = 1.
- x0 and unused operand: st_rd[0] = 0 with ex_rs1 = 0 → forwardA = 0. ex_rs1 = 3 matching with ex_rs1_used = 0 → forwardA = 0, no stall.
- Scoreboard countdown: mc_issue with mc_rd = 9, mc_lat = 3:
  - same cycle, id_rs1 = 9 → stall = 1 (bypass);
  - busy_vec[9] = 1 for exactly 3 cycles, then 0;
  - stall_cnt advances by 4 in total.
  - mc_lat = 0 → busy exactly 1 cycle.
- Store forward: me_mem_write = 1, me_rs2 = 4, st_rd[1] = 4, st_we[1] = 1, st_rdy[1] = 1 → forward_data = 2. Same with me_mem_write = 0 → forward_data = 0.
- Async reset mid-op: issue mc_rd = 12, mc_lat = 10; drop rstn for half a cycle → busy_vec = 0, stall_cnt = 0 immediately, with no clock edge required.
